// File: rtl/and_reduce_pipe.sv
// Purpose : pipelined WIDTH-bit all-ones detector built from a tree of FAN-input AND stages.
// Latency : STAGES = max(1, ceil(log_FAN(WIDTH))) enabled clock edges from I/I_VALID to O/O_VALID.
// Backpr. : none; one sample per enabled cycle, EN=0 freezes every stage in place.
//
// Ports
//   CLK         rising-edge clock
//   RST         asynchronous reset, active-high; clears all data and valid registers
//   EN          pipeline advance enable; 0 = every stage holds, I/I_VALID ignored
//   I           WIDTH-bit operand vector
//   I_VALID     I carries a sample this cycle
//   O           AND of all bits of the sample, meaningful only while O_VALID=1
//   O_VALID     O carries a result this cycle
//   STICKY      (AND_REDUCE_STICKY_EN) a valid zero result has been emitted since last clear
//   STICKY_CLR  (AND_REDUCE_STICKY_EN) synchronous clear of STICKY, independent of EN
//
// Optional feature macro: AND_REDUCE_STICKY_EN adds the STICKY/STICKY_CLR ports and one register.

module and_reduce_pipe #(
    parameter int WIDTH = 16,
    parameter int FAN   = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] I,
    input  logic             I_VALID,
    output logic             O,
    output logic             O_VALID
`ifdef AND_REDUCE_STICKY_EN
    ,
    output logic             STICKY,
    input  logic             STICKY_CLR
`endif
);

    // Number of live bits left after k reduction stages.
    function automatic int stage_w(input int k);
        int w;
        w = WIDTH;
        for (int i = 0; i < k; i++) begin
            w = (w + FAN - 1) / FAN;
        end
        return w;
    endfunction

    // Stages needed to bring WIDTH bits down to one; a 1-bit input still gets one register
    // so that every configuration has at least one cycle of latency.
    function automatic int calc_stages();
        int w;
        int n;
        w = WIDTH;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (w > 1) begin
                w = (w + FAN - 1) / FAN;
                n = n + 1;
            end
        end
        return (n < 1) ? 1 : n;
    endfunction

    localparam int STAGES = calc_stages();

    // Each level is carried at full WIDTH; bits above the live width of a level are tied to 1
    // so they can be folded into the last group without changing the result.
    logic [WIDTH-1:0] w_lvl [STAGES];
    logic [STAGES:0]  w_vld;

    assign w_lvl[0] = I;
    assign w_vld[0] = I_VALID;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        localparam int OUT_W = stage_w(g + 1);

        logic [OUT_W-1:0] w_and;
        logic [OUT_W-1:0] r_dat;
        logic             r_vld;

        // Group j covers bits [j*FAN +: FAN]; the last group also absorbs every bit above
        // it, which are either the partial tail or the 1-padding, so all-ones is preserved.
        for (genvar j = 0; j < OUT_W; j++) begin : g_grp
            localparam int LO = j * FAN;
            localparam int HI = (j == OUT_W - 1) ? (WIDTH - 1) : (LO + FAN - 1);
            assign w_and[j] = &w_lvl[g][HI:LO];
        end

        // Data regs load whenever the pipe advances, even for invalid samples; the
        // matching valid bit is what tells the consumer whether to look.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_dat <= '0;
            end else if (EN) begin
                r_dat <= w_and;
            end
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_vld <= 1'b0;
            end else if (EN) begin
                r_vld <= w_vld[g];
            end
        end

        assign w_vld[g+1] = r_vld;

        if (g < STAGES - 1) begin : g_mid
            assign w_lvl[g+1] = {{(WIDTH - OUT_W){1'b1}}, r_dat};
        end else begin : g_last
            // The final stage always narrows to exactly one bit.
            assign O = r_dat[0];
        end
    end

    assign O_VALID = w_vld[STAGES];

`ifdef AND_REDUCE_STICKY_EN
    logic r_sticky;

    // Watches the registered output, so a zero result shows up on STICKY one cycle after
    // it is presented. Set has priority over clear so a zero arriving during a clear is kept.
    // While EN=0 holds a valid zero on the output, the set simply keeps re-asserting.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sticky <= 1'b0;
        end else if (O_VALID && !O) begin
            r_sticky <= 1'b1;
        end else if (STICKY_CLR) begin
            r_sticky <= 1'b0;
        end
    end

    assign STICKY = r_sticky;
`endif

endmodule

// File: tb/tb_and_reduce_pipe.sv
// Purpose : randomized + directed scoreboard bench for and_reduce_pipe at WIDTH 16/5/17/1, FAN 4.
// Latency : expected results carry the enabled-edge index at which they must appear.
// Backpr. : none in the DUT; EN stalls are modelled as edges that do not advance the pipe.

module tb_and_reduce_pipe;

    localparam int FAN  = 4;
    localparam int NDUT = 4;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST;
    logic        EN;
    logic        I_VALID;
    logic        STICKY_CLR;
    logic [15:0] d16;
    logic [4:0]  d5;
    logic [16:0] d17;
    logic        d1;
    logic [NDUT-1:0] o;
    logic [NDUT-1:0] ov;
`ifdef AND_REDUCE_STICKY_EN
    logic [NDUT-1:0] st;
`endif

    and_reduce_pipe #(.WIDTH(16), .FAN(FAN)) u_w16 (
        .CLK(CLK), .RST(RST), .EN(EN), .I(d16), .I_VALID(I_VALID), .O(o[0]), .O_VALID(ov[0])
`ifdef AND_REDUCE_STICKY_EN
        , .STICKY(st[0]), .STICKY_CLR(STICKY_CLR)
`endif
    );
    and_reduce_pipe #(.WIDTH(5), .FAN(FAN)) u_w5 (
        .CLK(CLK), .RST(RST), .EN(EN), .I(d5), .I_VALID(I_VALID), .O(o[1]), .O_VALID(ov[1])
`ifdef AND_REDUCE_STICKY_EN
        , .STICKY(st[1]), .STICKY_CLR(STICKY_CLR)
`endif
    );
    and_reduce_pipe #(.WIDTH(17), .FAN(FAN)) u_w17 (
        .CLK(CLK), .RST(RST), .EN(EN), .I(d17), .I_VALID(I_VALID), .O(o[2]), .O_VALID(ov[2])
`ifdef AND_REDUCE_STICKY_EN
        , .STICKY(st[2]), .STICKY_CLR(STICKY_CLR)
`endif
    );
    and_reduce_pipe #(.WIDTH(1), .FAN(FAN)) u_w1 (
        .CLK(CLK), .RST(RST), .EN(EN), .I(d1), .I_VALID(I_VALID), .O(o[3]), .O_VALID(ov[3])
`ifdef AND_REDUCE_STICKY_EN
        , .STICKY(st[3]), .STICKY_CLR(STICKY_CLR)
`endif
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic val;
        int   due;
    } exp_t;

    exp_t sb [NDUT][$];
    int   widths [NDUT] = '{16, 5, 17, 1};
    int   lat    [NDUT];
    int   n_edge  = 0;
    bit   edge_en = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Smallest s >= 1 with FAN**s >= w.
    function automatic int stages_for(input int w);
        int s;
        int p;
        s = 1;
        p = FAN;
        while (p < w) begin
            p = p * FAN;
            s = s + 1;
        end
        return s;
    endfunction

    function automatic logic all_ones(input int idx);
        int v;
        int full;
        full = (1 << widths[idx]) - 1;
        case (idx)
            0:       v = int'(d16);
            1:       v = int'(d5);
            2:       v = int'(d17);
            default: v = int'(d1);
        endcase
        return v == full;
    endfunction

    initial begin
        for (int i = 0; i < NDUT; i++) lat[i] = stages_for(widths[i]);
    end

    // Input sampler: each enabled edge accepts a sample; its result is due
    // lat-1 enabled edges later (lat counts the sampling edge itself).
    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NDUT; i++) sb[i].delete();
            edge_en = 1'b0;
        end else if (EN) begin
            n_edge  = n_edge + 1;
            edge_en = 1'b1;
            if (I_VALID) begin
                for (int i = 0; i < NDUT; i++) begin
                    exp_t e;
                    e.val = all_ones(i);
                    e.due = n_edge + lat[i] - 1;
                    sb[i].push_back(e);
                end
            end
        end else begin
            edge_en = 1'b0;
        end
    end

    task automatic check(input string name, input int idx, input logic act, input logic expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s w%0d at %0t: got %b, expected %b", name, widths[idx], $time, act, expv);
        end
    endtask

    logic m_ov [NDUT];
    logic m_o  [NDUT];
    logic m_st [NDUT];
    logic p_ov [NDUT];
    logic p_o  [NDUT];
    logic p_clr = 1'b0;

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            m_ov[i] = 1'b0; m_o[i] = 1'b0; m_st[i] = 1'b0;
            p_ov[i] = 1'b0; p_o[i] = 1'b0;
        end
    end

    // Output monitor: compares the DUT outputs against the model state for this cycle.
    always @(negedge CLK) begin
        for (int i = 0; i < NDUT; i++) begin
            // Sticky sees the output that was on the wires at the last edge.
            if (RST)                     m_st[i] = 1'b0;
            else if (p_ov[i] && !p_o[i]) m_st[i] = 1'b1;
            else if (p_clr)              m_st[i] = 1'b0;

            if (RST) begin
                m_ov[i] = 1'b0;
                m_o[i]  = 1'b0;
            end else if (edge_en) begin
                if (sb[i].size() > 0 && sb[i][0].due < n_edge) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL missed_result w%0d at %0t: got no output, expected %b at edge %0d",
                             widths[i], $time, sb[i][0].val, sb[i][0].due);
                    void'(sb[i].pop_front());
                end
                if (sb[i].size() > 0 && sb[i][0].due == n_edge) begin
                    m_ov[i] = 1'b1;
                    m_o[i]  = sb[i][0].val;
                    void'(sb[i].pop_front());
                end else begin
                    m_ov[i] = 1'b0;
                end
            end
            // With no enabled edge the model simply holds its previous outputs.

            check("o_valid", i, ov[i], m_ov[i]);
            if (m_ov[i]) check("o_value", i, o[i], m_o[i]);
            if (RST) check("o_reset", i, o[i], 1'b0);
`ifdef AND_REDUCE_STICKY_EN
            check("sticky", i, st[i], m_st[i]);
`endif
            p_ov[i] = m_ov[i];
            p_o[i]  = m_o[i];
        end
        p_clr = STICKY_CLR;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_all(input logic [16:0] v);
        d17 = v;
        d16 = v[15:0];
        d5  = v[4:0];
        d1  = v[0];
    endtask

    // Biased so all-ones and single-zero patterns are common at every width.
    function automatic logic [31:0] gen(input int w);
        logic [31:0] full;
        logic [31:0] r;
        full = (32'd1 << w) - 32'd1;
        case ($urandom % 4)
            0, 1:    r = full;
            2:       r = full ^ (32'd1 << $urandom_range(0, w - 1));
            default: r = $urandom & full;
        endcase
        return r;
    endfunction

    initial begin
        logic [16:0] pat [4];
        logic [31:0] g;
        RST = 1'b1; EN = 1'b1; I_VALID = 1'b0; STICKY_CLR = 1'b0;
        set_all(17'h0);

        // Reset held, then idle: nothing may come out.
        repeat (3) step();
        RST = 1'b0;
        repeat (3) step();

        // Single all-ones sample.
        set_all(17'h1FFFF); I_VALID = 1'b1; step();
        I_VALID = 1'b0; repeat (4) step();

        // Back-to-back mixed samples.
        pat[0] = 17'h1FFFF; pat[1] = 17'h1FFFE; pat[2] = 17'h17FFF; pat[3] = 17'h1FFFF;
        for (int k = 0; k < 4; k++) begin
            set_all(pat[k]); I_VALID = 1'b1; step();
        end
        I_VALID = 1'b0; repeat (4) step();

        // Stall for three cycles right after accepting a sample.
        set_all(17'h1FFFF); I_VALID = 1'b1; step();
        I_VALID = 1'b0; EN = 1'b0; set_all(17'h0);
        repeat (3) step();
        EN = 1'b1; repeat (4) step();

        // Reset pulse in the middle of a stream.
        set_all(17'h1FFFF); I_VALID = 1'b1;
        repeat (3) step();
        RST = 1'b1; step();
        RST = 1'b0; repeat (4) step();
        I_VALID = 1'b0; repeat (4) step();

        // Zero result, later cleared; then a clear overlapping a new zero result.
        set_all(17'h1FFFE); I_VALID = 1'b1; step();
        I_VALID = 1'b0; repeat (4) step();
        STICKY_CLR = 1'b1; step();
        STICKY_CLR = 1'b0; step();
        I_VALID = 1'b1; step();
        I_VALID = 1'b0; STICKY_CLR = 1'b1;
        repeat (4) step();
        STICKY_CLR = 1'b0; repeat (2) step();

        // Random traffic with stalls, clears and occasional resets.
        repeat (400) begin
            EN         = ($urandom % 10) < 8;
            I_VALID    = ($urandom % 10) < 7;
            STICKY_CLR = ($urandom % 10) == 0;
            RST        = ($urandom % 100) == 0;
            g = gen(16); d16 = g[15:0];
            g = gen(5);  d5  = g[4:0];
            g = gen(17); d17 = g[16:0];
            g = gen(1);  d1  = g[0];
            step();
        end

        // Drain and confirm every issued sample came out.
        RST = 1'b0; EN = 1'b1; I_VALID = 1'b0; STICKY_CLR = 1'b0;
        repeat (6) step();
        for (int i = 0; i < NDUT; i++) begin
            n_tests++;
            if (sb[i].size() != 0) begin
                n_fail++;
                $display("FAIL drain w%0d: %0d results outstanding, expected 0", widths[i], sb[i].size());
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
